// File: rtl/cmp_pkg.sv
// Shared types for the sequential compare unit: operation encoding, FSM states
// and the signed-operation helper.
package cmp_pkg;

    typedef enum logic [2:0] {
        SLT  = 3'd0,
        SLTU = 3'd1,
        MIN  = 3'd2,
        MINU = 3'd3,
        MAX  = 3'd4,
        MAXU = 3'd5,
        EQ   = 3'd6,
        RSV  = 3'd7
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    function automatic logic is_signed(input cmp_op_e op);
        return (op == SLT) || (op == MIN) || (op == MAX);
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Unsigned magnitude compare of one CHUNK-bit slice of the operands.
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt_o,
    output logic             gt_o
);

    assign lt_o = (a < b);
    assign gt_o = (a > b);

endmodule

// File: rtl/seq_compare_unit.sv
// Multi-cycle integer compare unit: one CHUNK-bit slice per cycle, MSB slice first.
// Define CMP_EARLY_EXIT_EN to finish on the first differing slice (data-dependent latency).
module seq_compare_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  cmp_op_e          op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] rd_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    cmp_state_e       state_q;
    cmp_op_e          op_q;
    logic [WIDTH-1:0] rs1_q, rs2_q, rd_q;
    logic [IDXW-1:0]  idx_q;
    logic             lt_q, gt_q;

    logic [WIDTH-1:0] sign_mask, a_x, b_x, rd_next;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic             chunk_lt, chunk_gt, lt_next, gt_next, last_chunk;

    // Flipping the sign bit of both operands maps signed order onto unsigned order.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sign_mask            = '0;
        sign_mask[WIDTH-1]   = is_signed(op_q);
        a_x                  = rs1_q ^ sign_mask;
        b_x                  = rs2_q ^ sign_mask;
        a_chunk              = a_x[idx_q*CHUNK +: CHUNK];
        b_chunk              = b_x[idx_q*CHUNK +: CHUNK];
    end

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .lt_o (chunk_lt),
        .gt_o (chunk_gt)
    );

    // The first differing slice from the MSB decides; later slices are ignored.
    always_comb begin
        lt_next    = (lt_q || gt_q) ? lt_q : chunk_lt;
        gt_next    = (lt_q || gt_q) ? gt_q : chunk_gt;
`ifdef CMP_EARLY_EXIT_EN
        last_chunk = (idx_q == '0) || lt_next || gt_next;
`else
        last_chunk = (idx_q == '0);
`endif
    end

    always_comb begin
        rd_next = '0;
        case (op_q)
            SLT, SLTU: rd_next = {{(WIDTH-1){1'b0}}, lt_next};
            EQ:        rd_next = {{(WIDTH-1){1'b0}}, !lt_next && !gt_next};
            MIN, MINU: rd_next = lt_next ? rs1_q : rs2_q;
            MAX, MAXU: rd_next = gt_next ? rs1_q : rs2_q;
            default:   rd_next = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: all state, including operand and result registers, is cleared so rd_o reads 0 out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= SLT;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_q    <= op_i;
                        rs1_q   <= rs1_i;
                        rs2_q   <= rs2_i;
                        idx_q   <= LAST_IDX;
                        lt_q    <= 1'b0;
                        gt_q    <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    lt_q  <= lt_next;
                    gt_q  <= gt_next;
                    idx_q <= idx_q - IDXW'(1);
                    if (last_chunk) begin
                        rd_q    <= rd_next;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign rd_o    = rd_q;

endmodule
